// File: rtl/data_memory_responder.sv
// data_memory_responder: multi-cycle data memory answering the CPU MEM-stage
// load/store requests. One request is in flight at a time. The pipeline is
// stalled while the access is in flight. Load data and stores complete on the
// edge that enters RESP.
// Optional feature: define DMEM_ALIGN_CHECK_EN to flag misaligned word accesses.
module data_memory_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic        req_byte,
  input  logic [15:0] req_address,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic        mem_stall,
  output logic        align_error
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam bit   SINGLE = (LATENCY == 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] cnt;

  logic             lat_write;
  logic             lat_byte;
  logic [15:0]      lat_address;
  logic [15:0]      lat_wdata;

  logic [15:0]      mem [DEPTH];

  logic             accept;
  logic             enter_resp;
  logic             acc_write;
  logic             acc_byte;
  logic [15:0]      acc_address;
  logic [15:0]      acc_wdata;
  logic [AW-1:0]    acc_index;
  logic             acc_hi;
  logic             misaligned;
  logic [15:0]      cur_word;

  // Upper address bits are intentionally discarded (addresses wrap).
  logic             unused_addr;
  assign unused_addr = ^{lat_address, req_address};

  // Replace the addressed byte of a word, leaving the other byte intact.
  function automatic logic [15:0] byte_merge(input logic [15:0] word,
                                             input logic [7:0]  data,
                                             input logic        hi);
    byte_merge = hi ? {data, word[7:0]} : {word[15:8], data};
  endfunction

  // Format load data: full word, or the addressed byte zero-extended.
  function automatic logic [15:0] load_format(input logic [15:0] word,
                                              input logic        is_byte,
                                              input logic        hi);
    if (!is_byte)
      load_format = word;
    else
      load_format = {8'h00, (hi ? word[15:8] : word[7:0])};
  endfunction

  assign accept     = (state == IDLE) && req_valid;
  assign enter_resp = (accept && SINGLE) || ((state == WAIT) && (cnt == CNT_ONE));
  assign mem_stall  = accept || (state == WAIT);

  // With LATENCY=1 the access completes on the acceptance edge, so the live
  // request fields are used in IDLE and the latched copy otherwise.
  assign acc_write   = (state == IDLE) ? req_write   : lat_write;
  assign acc_byte    = (state == IDLE) ? req_byte    : lat_byte;
  assign acc_address = (state == IDLE) ? req_address : lat_address;
  assign acc_wdata   = (state == IDLE) ? req_wdata   : lat_wdata;
  assign acc_index   = acc_address[AW:1];
  assign acc_hi      = acc_address[0];
  assign cur_word    = mem[acc_index];

`ifdef DMEM_ALIGN_CHECK_EN
  assign misaligned = !acc_byte && acc_hi;
`else
  assign misaligned = 1'b0;
`endif

  // Next-state selection for the IDLE/WAIT/RESP sequencer.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = SINGLE ? RESP : WAIT;
      WAIT:    if (cnt == CNT_ONE) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Sequencer state and latency counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (accept)
        cnt <= CNT_LOAD;
      else if (state == WAIT)
        cnt <= cnt - CNT_ONE;
    end
  end

  // Request fields captured at acceptance; later input changes are ignored.
  always_ff @(posedge clock) begin
    if (accept) begin
      lat_write   <= req_write;
      lat_byte    <= req_byte;
      lat_address <= req_address;
      lat_wdata   <= req_wdata;
    end
  end

  // Memory array: cleared by reset, written only on the edge entering RESP.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (enter_resp && acc_write && !misaligned) begin
      mem[acc_index] <= acc_byte ? byte_merge(cur_word, acc_wdata[7:0], acc_hi)
                                 : acc_wdata;
    end
  end

  // Response strobe, error flag and registered load data (held between responses).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      resp_valid  <= 1'b0;
      align_error <= 1'b0;
      resp_rdata  <= '0;
    end else begin
      resp_valid  <= enter_resp;
      align_error <= enter_resp && misaligned;
      if (enter_resp)
        resp_rdata <= (acc_write || misaligned) ? 16'h0000
                                                : load_format(cur_word, acc_byte, acc_hi);
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Testbench for data_memory_responder: table of requests with expected
// responses kept on a scoreboard queue, plus reset and abort sequences.
module tb_data_memory_responder;

  localparam int LAT = 2;
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN_ON = 1'b1;
`else
  localparam bit ALIGN_ON = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic        req_byte;
  logic [15:0] req_address;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic        mem_stall;
  logic        align_error;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        wr;
    logic        by;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    logic        exp_align;
  } vec_t;

  typedef struct {
    logic [15:0] rdata;
    logic        align;
  } exp_t;

  exp_t sb[$];
  vec_t tv[15];

  always #5 clock = ~clock;

  data_memory_responder #(.DEPTH(256), .LATENCY(LAT)) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_write   (req_write),
    .req_byte    (req_byte),
    .req_address (req_address),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .mem_stall   (mem_stall),
    .align_error (align_error)
  );

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Issue one request, scramble the inputs after acceptance, then wait
  // (bounded) for the response and compare it against the scoreboard.
  task automatic run_req(input string nm, input logic wr, input logic by,
                         input logic [15:0] addr, input logic [15:0] wd,
                         input logic [15:0] exp_rd, input logic exp_al);
    int   cycles;
    int   stalls;
    bit   got;
    exp_t e;
    @(negedge clock);
    req_valid   = 1'b1;
    req_write   = wr;
    req_byte    = by;
    req_address = addr;
    req_wdata   = wd;
    sb.push_back('{rdata: exp_rd, align: exp_al});
    cycles = 0;
    stalls = 0;
    got    = 1'b0;
    #1;
    if (mem_stall) stalls++;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clock);
      if (i == 0) begin
        req_valid   = 1'b0;
        req_write   = ~wr;
        req_byte    = ~by;
        req_address = 16'($urandom);
        req_wdata   = 16'($urandom);
      end
      cycles++;
      #1;
      if (resp_valid) got = 1'b1;
      else if (mem_stall) stalls++;
    end
    e = sb.pop_front();
    if (!got) begin
      chk({nm, " timeout"}, 16'd0, 16'd1);
    end else begin
      chk({nm, " rdata"}, resp_rdata, e.rdata);
      chk({nm, " align_error"}, {15'd0, align_error}, {15'd0, e.align});
      chk({nm, " latency"}, 16'(cycles), 16'(LAT));
      chk({nm, " stall cycles"}, 16'(stalls), 16'(LAT));
      chk({nm, " stall in RESP"}, {15'd0, mem_stall}, 16'd0);
      @(negedge clock);
      #1;
      chk({nm, " strobe width"}, {15'd0, resp_valid}, 16'd0);
      chk({nm, " rdata hold"}, resp_rdata, e.rdata);
      chk({nm, " align clears"}, {15'd0, align_error}, 16'd0);
    end
  endtask

  initial begin
    tv[0]  = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0000, 1'b0};
    tv[1]  = '{1'b1, 1'b0, 16'h0004, 16'hBEEF, 16'h0000, 1'b0};
    tv[2]  = '{1'b0, 1'b0, 16'h0004, 16'h0000, 16'hBEEF, 1'b0};
    tv[3]  = '{1'b1, 1'b1, 16'h0005, 16'hFF12, 16'h0000, 1'b0};
    tv[4]  = '{1'b0, 1'b0, 16'h0004, 16'h0000, 16'h12EF, 1'b0};
    tv[5]  = '{1'b0, 1'b1, 16'h0004, 16'h0000, 16'h00EF, 1'b0};
    tv[6]  = '{1'b0, 1'b1, 16'h0005, 16'h0000, 16'h0012, 1'b0};
    tv[7]  = '{1'b1, 1'b0, 16'h0200, 16'h1111, 16'h0000, 1'b0};
    tv[8]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h1111, 1'b0};
    tv[9]  = '{1'b1, 1'b1, 16'h0004, 16'hAB34, 16'h0000, 1'b0};
    tv[10] = '{1'b0, 1'b0, 16'h0004, 16'h0000, 16'h1234, 1'b0};
    tv[11] = '{1'b1, 1'b0, 16'h0003, 16'h5555, 16'h0000, ALIGN_ON};
    tv[12] = '{1'b0, 1'b0, 16'h0002, 16'h0000, ALIGN_ON ? 16'h0000 : 16'h5555, 1'b0};
    tv[13] = '{1'b0, 1'b0, 16'h0003, 16'h0000, ALIGN_ON ? 16'h0000 : 16'h5555, ALIGN_ON};
    tv[14] = '{1'b0, 1'b0, 16'hFE04, 16'h0000, 16'h1234, 1'b0};

    reset       = 1'b1;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_byte    = 1'b0;
    req_address = 16'h0000;
    req_wdata   = 16'h0000;
    #12;
    chk("reset resp_valid",  {15'd0, resp_valid},  16'd0);
    chk("reset resp_rdata",  resp_rdata,           16'd0);
    chk("reset mem_stall",   {15'd0, mem_stall},   16'd0);
    chk("reset align_error", {15'd0, align_error}, 16'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    #1;
    chk("idle resp_valid", {15'd0, resp_valid}, 16'd0);
    chk("idle mem_stall",  {15'd0, mem_stall},  16'd0);

    for (int i = 0; i < 15; i++)
      run_req($sformatf("vec%0d", i), tv[i].wr, tv[i].by, tv[i].addr,
              tv[i].wdata, tv[i].exp_rdata, tv[i].exp_align);

    // Abort a store with reset while it waits; nothing may be written.
    @(negedge clock);
    req_valid   = 1'b1;
    req_write   = 1'b1;
    req_byte    = 1'b0;
    req_address = 16'h0008;
    req_wdata   = 16'hAAAA;
    @(negedge clock);
    req_valid = 1'b0;
    #1;
    chk("abort in WAIT stall", {15'd0, mem_stall}, 16'd1);
    reset = 1'b1;
    #1;
    chk("abort resp_valid", {15'd0, resp_valid}, 16'd0);
    chk("abort resp_rdata", resp_rdata,          16'd0);
    chk("abort mem_stall",  {15'd0, mem_stall},  16'd0);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      #1;
      chk($sformatf("abort no resp %0d", i), {15'd0, resp_valid}, 16'd0);
    end
    run_req("after abort 0x0008", 1'b0, 1'b0, 16'h0008, 16'h0000, 16'h0000, 1'b0);
    run_req("after abort 0x0004", 1'b0, 1'b0, 16'h0004, 16'h0000, 16'h0000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
